// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Merges the CPU's instruction-fetch port (A) and load/store
//                port (B) onto one physical memory port. One transaction is
//                in flight at a time; the winner's request is latched and the
//                shared port is driven from registers. The response is routed
//                only to the granted requester.
//  Options     : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests in
//                IDLE alternate between ports (the one not granted last).
//                When undefined, port B always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int WORD_W = 16,
  parameter int MASK_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              mem_read_a,
  input  logic              mem_write_a,
  input  logic [MASK_W-1:0] mem_byte_enable_a,
  input  logic [WORD_W-1:0] mem_address_a,
  input  logic [WORD_W-1:0] mem_wdata_a,
  output logic              mem_resp_a,
  output logic [WORD_W-1:0] mem_rdata_a,
  // load/store port
  input  logic              mem_read_b,
  input  logic              mem_write_b,
  input  logic [MASK_W-1:0] mem_byte_enable_b,
  input  logic [WORD_W-1:0] mem_address_b,
  input  logic [WORD_W-1:0] mem_wdata_b,
  output logic              mem_resp_b,
  output logic [WORD_W-1:0] mem_rdata_b,
  // shared physical port
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [MASK_W-1:0] pmem_byte_enable,
  output logic [WORD_W-1:0] pmem_address,
  output logic [WORD_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [WORD_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [MASK_W-1:0] be_q, be_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_a_q, rdata_a_d;
  logic [WORD_W-1:0] rdata_b_q, rdata_b_d;

  logic              req_a;
  logic              req_b;
  logic              pick_b;
  logic              sel_read;
  logic              sel_write;
  logic [MASK_W-1:0] sel_be;
  logic [WORD_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;

  assign req_a = mem_read_a | mem_write_a;
  assign req_b = mem_read_b | mem_write_b;

  // Choose which port would win if arbitration happens this cycle
  always_comb begin
    pick_b = req_b;
    if (req_a && req_b) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_b = (last_grant_q == GRANT_A);
`else
      pick_b = 1'b1;
`endif
    end
  end

  assign sel_read  = pick_b ? mem_read_b        : mem_read_a;
  assign sel_write = pick_b ? mem_write_b       : mem_write_a;
  assign sel_be    = pick_b ? mem_byte_enable_b : mem_byte_enable_a;
  assign sel_addr  = pick_b ? mem_address_b     : mem_address_a;
  assign sel_wdata = pick_b ? mem_wdata_b       : mem_wdata_a;

  // Next-state, request latching and completion handling
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d      = pick_b ? SERVE_B : SERVE_A;
          // a request with both read and write set is carried out as a write
          pmem_read_d  = sel_read & ~sel_write;
          pmem_write_d = sel_write;
          be_d         = sel_be;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
        end
      end
      SERVE_A: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = GRANT_A;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          rdata_a_d    = pmem_rdata;
        end
      end
      SERVE_B: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = GRANT_B;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          rdata_b_d    = pmem_rdata;
        end
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the strobes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_A;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
    end
  end

  assign pmem_read        = pmem_read_q;
  assign pmem_write       = pmem_write_q;
  assign pmem_byte_enable = be_q;
  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;

  // Completion is forwarded in the same cycle; idle-time responses are dropped
  assign mem_resp_a  = (state_q == SERVE_A) && pmem_resp;
  assign mem_resp_b  = (state_q == SERVE_B) && pmem_resp;
  assign mem_rdata_a = mem_resp_a ? pmem_rdata : rdata_a_q;
  assign mem_rdata_b = mem_resp_b ? pmem_rdata : rdata_b_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Acts as both
//                requesters and as the downstream memory; expected grants,
//                strobes and routed data come from a transaction-level model.
//                Honours ARB_ROUND_ROBIN_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int WORD_W = 16;
  localparam int MASK_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_read_a, mem_write_a, mem_read_b, mem_write_b;
  logic [MASK_W-1:0] mem_byte_enable_a, mem_byte_enable_b;
  logic [WORD_W-1:0] mem_address_a, mem_wdata_a, mem_address_b, mem_wdata_b;
  logic              mem_resp_a, mem_resp_b;
  logic [WORD_W-1:0] mem_rdata_a, mem_rdata_b;
  logic              pmem_read, pmem_write, pmem_resp;
  logic [MASK_W-1:0] pmem_byte_enable;
  logic [WORD_W-1:0] pmem_address, pmem_wdata, pmem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_W(WORD_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .reset(reset),
    .mem_read_a(mem_read_a), .mem_write_a(mem_write_a),
    .mem_byte_enable_a(mem_byte_enable_a), .mem_address_a(mem_address_a),
    .mem_wdata_a(mem_wdata_a), .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_byte_enable_b(mem_byte_enable_b), .mem_address_b(mem_address_b),
    .mem_wdata_b(mem_wdata_b), .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_byte_enable(pmem_byte_enable), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  // model state: last data delivered per port, and who was granted last
  logic [WORD_W-1:0] exp_last_a, exp_last_b;
  logic              exp_last_grant_b;

  typedef struct {
    int                grant_lat;
    bit                timeout;
    logic              rd, wr;
    logic [MASK_W-1:0] be;
    logic [WORD_W-1:0] addr, wdata;
    bit                stable;
    bit                early_resp;
    logic              resp_a, resp_b;
    logic [WORD_W-1:0] rdata_a, rdata_b;
    logic              strobe_after;
  } obs_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_a = 0; mem_write_a = 0; mem_byte_enable_a = '0;
    mem_address_a = '0; mem_wdata_a = '0;
    mem_read_b = 0; mem_write_b = 0; mem_byte_enable_b = '0;
    mem_address_b = '0; mem_wdata_b = '0;
  endtask

  // Tie-break rule: B on fixed priority, otherwise the port not granted last
  function automatic logic tie_winner_b();
`ifdef ARB_ROUND_ROBIN_EN
    return !exp_last_grant_b;
`else
    return 1'b1;
`endif
  endfunction

  task automatic note_done(input logic win_b, input logic [WORD_W-1:0] data);
    exp_last_grant_b = win_b;
    if (win_b) exp_last_b = data;
    else       exp_last_a = data;
  endtask

  // Plays the memory side of one transaction; records what was observed.
  task automatic do_txn(input int lat, input logic [WORD_W-1:0] data, output obs_t o);
    o = '{default: '0};
    o.timeout = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (pmem_read || pmem_write) begin
        o.grant_lat = k;
        o.timeout   = 0;
        break;
      end
    end
    if (o.timeout) return;
    o.rd = pmem_read; o.wr = pmem_write; o.be = pmem_byte_enable;
    o.addr = pmem_address; o.wdata = pmem_wdata;
    o.stable = 1;
    if (mem_resp_a || mem_resp_b) o.early_resp = 1;
    for (int i = 1; i < lat; i++) begin
      tick();
      if ({pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata} !==
          {o.rd, o.wr, o.be, o.addr, o.wdata}) o.stable = 0;
      if (mem_resp_a || mem_resp_b) o.early_resp = 1;
    end
    pmem_resp  = 1;
    pmem_rdata = data;
    #1;
    o.resp_a = mem_resp_a; o.resp_b = mem_resp_b;
    o.rdata_a = mem_rdata_a; o.rdata_b = mem_rdata_b;
    tick();
    pmem_resp  = 0;
    pmem_rdata = 16'($urandom);
    o.strobe_after = pmem_read | pmem_write;
  endtask

  task automatic test_reset();
    idle_inputs();
    pmem_resp = 0; pmem_rdata = '0;
    reset = 1;
    tick(); tick();
    exp_last_a = '0; exp_last_b = '0; exp_last_grant_b = 0;
    checks++;
    if ({pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_pmem got rd=%b wr=%b be=%b addr=%h wd=%h exp all zero",
               pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata);
    end
    checks++;
    if ({mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b} !== '0) begin
      errors++;
      $display("FAIL reset_resp got ra=%b rb=%b da=%h db=%h exp all zero",
               mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b);
    end
    reset = 0;
    tick();
    // a stray response while idle must not be forwarded
    pmem_resp = 1; pmem_rdata = 16'hDEAD;
    #1;
    checks++;
    if ({mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b} !== '0) begin
      errors++;
      $display("FAIL idle_resp got ra=%b rb=%b da=%h db=%h exp all zero",
               mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b);
    end
    tick();
    pmem_resp = 0;
    checks++;
    if ({pmem_read, pmem_write, mem_rdata_a, mem_rdata_b} !== '0) begin
      errors++;
      $display("FAIL idle_after got rd=%b wr=%b da=%h db=%h exp all zero",
               pmem_read, pmem_write, mem_rdata_a, mem_rdata_b);
    end
  endtask

  task automatic test_single_fetch();
    obs_t o;
    mem_read_a = 1; mem_address_a = 16'h3000; mem_byte_enable_a = 2'b11;
    do_txn(3, 16'h1234, o);
    mem_read_a = 0;
    checks++;
    if (o.timeout || o.grant_lat != 1) begin
      errors++;
      $display("FAIL fetch_latency got %0d (timeout=%b) exp 1", o.grant_lat, o.timeout);
    end
    checks++;
    if ({o.rd, o.wr, o.addr, o.stable, o.early_resp} !== {1'b1, 1'b0, 16'h3000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fetch_strobe got rd=%b wr=%b addr=%h stable=%b early=%b exp 1 0 3000 1 0",
               o.rd, o.wr, o.addr, o.stable, o.early_resp);
    end
    checks++;
    if ({o.resp_a, o.resp_b, o.rdata_a, o.rdata_b} !== {1'b1, 1'b0, 16'h1234, exp_last_b}) begin
      errors++;
      $display("FAIL fetch_resp got ra=%b rb=%b da=%h db=%h exp 1 0 1234 %h",
               o.resp_a, o.resp_b, o.rdata_a, o.rdata_b, exp_last_b);
    end
    note_done(1'b0, 16'h1234);
    tick(); tick();
    checks++;
    if ({mem_resp_a, mem_resp_b, pmem_read, pmem_write, mem_rdata_a} !== {4'b0000, 16'h1234}) begin
      errors++;
      $display("FAIL fetch_after got ra=%b rb=%b rd=%b wr=%b da=%h exp 0 0 0 0 1234",
               mem_resp_a, mem_resp_b, pmem_read, pmem_write, mem_rdata_a);
    end
  endtask

  task automatic test_store();
    obs_t o;
    mem_write_b = 1; mem_address_b = 16'h4002; mem_wdata_b = 16'hBEEF;
    mem_byte_enable_b = 2'b10;
    do_txn(2, 16'h0F0F, o);
    mem_write_b = 0;
    checks++;
    if (o.timeout || {o.rd, o.wr, o.be, o.addr, o.wdata, o.stable} !==
        {1'b0, 1'b1, 2'b10, 16'h4002, 16'hBEEF, 1'b1}) begin
      errors++;
      $display("FAIL store_strobe got to=%b rd=%b wr=%b be=%b addr=%h wd=%h stable=%b exp 0 1 10 4002 beef 1",
               o.timeout, o.rd, o.wr, o.be, o.addr, o.wdata, o.stable);
    end
    checks++;
    if ({o.resp_a, o.resp_b, o.rdata_a, o.rdata_b} !== {1'b0, 1'b1, exp_last_a, 16'h0F0F}) begin
      errors++;
      $display("FAIL store_resp got ra=%b rb=%b da=%h db=%h exp 0 1 %h 0f0f",
               o.resp_a, o.resp_b, o.rdata_a, o.rdata_b, exp_last_a);
    end
    note_done(1'b1, 16'h0F0F);
  endtask

  task automatic test_tie();
    obs_t o;
    logic win_b;
    logic [WORD_W-1:0] data;
    int n;
    mem_read_a = 1; mem_address_a = 16'h3000; mem_byte_enable_a = 2'b11;
    mem_read_b = 1; mem_address_b = 16'h4002; mem_byte_enable_b = 2'b11;
    n = 4;
    for (int t = 0; t < n; t++) begin
      win_b = tie_winner_b();
      data  = 16'($urandom);
      do_txn(2, data, o);
      checks++;
      if (o.timeout || o.grant_lat != 1 || o.addr !== (win_b ? 16'h4002 : 16'h3000)) begin
        errors++;
        $display("FAIL tie_grant[%0d] got addr=%h lat=%0d to=%b exp addr=%h lat=1",
                 t, o.addr, o.grant_lat, o.timeout, win_b ? 16'h4002 : 16'h3000);
      end
      checks++;
      if ({o.resp_a, o.resp_b} !== {~win_b, win_b}) begin
        errors++;
        $display("FAIL tie_route[%0d] got ra=%b rb=%b exp %b %b", t, o.resp_a, o.resp_b, ~win_b, win_b);
      end
      note_done(win_b, data);
    end
    // once B lets go, A must be served
    mem_read_b = 0;
    data = 16'($urandom);
    do_txn(1, data, o);
    mem_read_a = 0;
    checks++;
    if (o.timeout || o.addr !== 16'h3000 || {o.resp_a, o.resp_b} !== 2'b10 || o.rdata_a !== data) begin
      errors++;
      $display("FAIL tie_release got addr=%h ra=%b rb=%b da=%h exp 3000 1 0 %h",
               o.addr, o.resp_a, o.resp_b, o.rdata_a, data);
    end
    note_done(1'b0, data);
    tick();
  endtask

  task automatic test_input_change();
    mem_read_b = 1; mem_address_b = 16'h4002; mem_byte_enable_b = 2'b01;
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 16'h4002}) begin
      errors++;
      $display("FAIL chg_grant got rd=%b addr=%h exp 1 4002", pmem_read, pmem_address);
    end
    mem_address_b = 16'h5000; mem_read_b = 0;
    tick();
    checks++;
    if ({pmem_read, pmem_address, pmem_byte_enable} !== {1'b1, 16'h4002, 2'b01}) begin
      errors++;
      $display("FAIL chg_hold got rd=%b addr=%h be=%b exp 1 4002 01",
               pmem_read, pmem_address, pmem_byte_enable);
    end
    pmem_resp = 1; pmem_rdata = 16'hA5C3;
    #1;
    checks++;
    if ({mem_resp_a, mem_resp_b, mem_rdata_b} !== {1'b0, 1'b1, 16'hA5C3}) begin
      errors++;
      $display("FAIL chg_resp got ra=%b rb=%b db=%h exp 0 1 a5c3", mem_resp_a, mem_resp_b, mem_rdata_b);
    end
    note_done(1'b1, 16'hA5C3);
    tick();
    pmem_resp = 0;
    tick();
    checks++;
    if ({pmem_read, pmem_write, mem_resp_b} !== 3'b000) begin
      errors++;
      $display("FAIL chg_idle got rd=%b wr=%b rb=%b exp 0 0 0", pmem_read, pmem_write, mem_resp_b);
    end
  endtask

  task automatic test_reset_mid_serve();
    mem_read_a = 1; mem_address_a = 16'h3000; mem_byte_enable_a = 2'b11;
    tick();
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++;
      $display("FAIL rst_grant got rd=%b exp 1", pmem_read);
    end
    tick();
    reset = 1;
    #1;
    checks++;
    if ({pmem_read, pmem_write, mem_resp_a} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async got rd=%b wr=%b ra=%b exp 0 0 0", pmem_read, pmem_write, mem_resp_a);
    end
    mem_read_a = 0;
    exp_last_a = '0; exp_last_b = '0; exp_last_grant_b = 0;
    tick();
    reset = 0;
    pmem_resp = 1; pmem_rdata = 16'h7777;
    #1;
    checks++;
    if ({mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b} !== '0) begin
      errors++;
      $display("FAIL rst_discard got ra=%b rb=%b da=%h db=%h exp all zero",
               mem_resp_a, mem_resp_b, mem_rdata_a, mem_rdata_b);
    end
    tick();
    pmem_resp = 0;
    checks++;
    if ({pmem_read, pmem_write} !== 2'b00) begin
      errors++;
      $display("FAIL rst_idle got rd=%b wr=%b exp 0 0", pmem_read, pmem_write);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic pa, pb, win_b, w_rd, w_wr;
    logic a_rd, a_wr, b_rd, b_wr;
    logic [MASK_W-1:0] a_be, b_be, w_be;
    logic [WORD_W-1:0] a_ad, a_wd, b_ad, b_wd, w_ad, w_wd, data;
    int kind;
    pa = 0; pb = 0;
    {a_rd, a_wr, b_rd, b_wr} = '0;
    a_be = '0; b_be = '0; a_ad = '0; a_wd = '0; b_ad = '0; b_wd = '0;
    for (int it = 0; it < 200; it++) begin
      if (!pa && ($urandom % 2 == 1)) pa = 1;
      if (!pb && ($urandom % 2 == 1)) pb = 1;
      if (!pa && !pb) begin
        if ($urandom % 2 == 1) pa = 1; else pb = 1;
      end
      if (pa && !(a_rd || a_wr)) begin
        kind = int'($urandom % 5);
        a_rd = (kind <= 2) || (kind == 4); a_wr = (kind >= 3);
        a_be = 2'($urandom); a_ad = 16'($urandom); a_wd = 16'($urandom);
      end
      if (pb && !(b_rd || b_wr)) begin
        kind = int'($urandom % 5);
        b_rd = (kind <= 2) || (kind == 4); b_wr = (kind >= 3);
        b_be = 2'($urandom); b_ad = 16'($urandom); b_wd = 16'($urandom);
      end
      mem_read_a = a_rd; mem_write_a = a_wr; mem_byte_enable_a = a_be;
      mem_address_a = a_ad; mem_wdata_a = a_wd;
      mem_read_b = b_rd; mem_write_b = b_wr; mem_byte_enable_b = b_be;
      mem_address_b = b_ad; mem_wdata_b = b_wd;
      win_b = (pa && pb) ? tie_winner_b() : pb;
      w_rd = win_b ? b_rd : a_rd;  w_wr = win_b ? b_wr : a_wr;
      w_be = win_b ? b_be : a_be;  w_ad = win_b ? b_ad : a_ad;
      w_wd = win_b ? b_wd : a_wd;
      data = 16'($urandom);
      do_txn(int'($urandom_range(1, 4)), data, o);
      checks++;
      if (o.timeout || o.grant_lat != 1 || !o.stable || o.early_resp) begin
        errors++;
        $display("FAIL rnd_timing[%0d] got lat=%0d to=%b stable=%b early=%b exp 1 0 1 0",
                 it, o.grant_lat, o.timeout, o.stable, o.early_resp);
      end
      checks++;
      if ({o.rd, o.wr, o.be, o.addr, o.wdata} !== {w_rd & ~w_wr, w_wr, w_be, w_ad, w_wd}) begin
        errors++;
        $display("FAIL rnd_strobe[%0d] got rd=%b wr=%b be=%b addr=%h wd=%h exp %b %b %b %h %h",
                 it, o.rd, o.wr, o.be, o.addr, o.wdata, w_rd & ~w_wr, w_wr, w_be, w_ad, w_wd);
      end
      note_done(win_b, data);
      checks++;
      if ({o.resp_a, o.resp_b, o.rdata_a, o.rdata_b, o.strobe_after} !==
          {~win_b, win_b, exp_last_a, exp_last_b, 1'b0}) begin
        errors++;
        $display("FAIL rnd_resp[%0d] got ra=%b rb=%b da=%h db=%h after=%b exp %b %b %h %h 0",
                 it, o.resp_a, o.resp_b, o.rdata_a, o.rdata_b, o.strobe_after,
                 ~win_b, win_b, exp_last_a, exp_last_b);
      end
      if (win_b) begin pb = 0; b_rd = 0; b_wr = 0; b_ad = 16'($urandom); end
      else       begin pa = 0; a_rd = 0; a_wr = 0; a_ad = 16'($urandom); end
      mem_read_a = a_rd; mem_write_a = a_wr; mem_address_a = a_ad;
      mem_read_b = b_rd; mem_write_b = b_wr; mem_address_b = b_ad;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_input_change();
    test_reset_mid_serve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the CPU datapath; merges its two word-wide memory ports onto one physical memory/cache port.
  - Port A: instruction fetch.
  - Port B: load/store queue.
- Grants one transaction at a time and latches the winner's request.
- Drives the shared port from registers and routes the response back to the granted requester only.

Parameters:
- WORD_W, 16, data/address width in bits (lc3b_word).
- MASK_W, 2, byte-enable width (lc3b_mem_wmask).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mem_read_a  in  1  fetch read request
- mem_write_a  in  1  fetch write request (normally 0)
- mem_byte_enable_a  in  MASK_W  fetch byte mask
- mem_address_a  in  WORD_W  fetch address
- mem_wdata_a  in  WORD_W  fetch write data
- mem_resp_a  out  1  fetch completion pulse
- mem_rdata_a  out  WORD_W  fetch read data
- mem_read_b, mem_write_b, mem_byte_enable_b, mem_address_b, mem_wdata_b  in  1/1/MASK_W/WORD_W/WORD_W  data-port request, same meaning as A
- mem_resp_b  out  1  data-port completion pulse
- mem_rdata_b  out  WORD_W  data-port read data
- pmem_read  out  1  shared-port read strobe
- pmem_write  out  1  shared-port write strobe
- pmem_byte_enable  out  MASK_W  shared-port byte mask
- pmem_address  out  WORD_W  shared-port address
- pmem_wdata  out  WORD_W  shared-port write data
- pmem_resp  in  1  shared-port completion
- pmem_rdata  in  WORD_W  shared-port read data

Behaviour:
- FSM states: IDLE, SERVE_A, SERVE_B. Reset (async) forces IDLE.
- Reset values:
  - pmem_read/pmem_write = 0, pmem_address/wdata/byte_enable regs = 0.
  - mem_resp_a/b = 0, mem_rdata_a/b = 0.
  - last_grant = A.
- Request definition: req_x = mem_read_x | mem_write_x.
- IDLE:
  - If any req, choose winner (fixed priority: B over A; see Optional Feature).
  - Latch winner's read, write, byte_enable, address, wdata into request regs.
  - Go to SERVE_x next cycle. No shared strobe is asserted in IDLE.
  - Minimum grant latency: 1 cycle from request to pmem strobe.
- SERVE_x:
  - pmem_read/pmem_write driven from latched regs.
  - If latched read and write are both 1, treat as write: pmem_read = 0, pmem_write = 1.
  - Address, wdata and mask are stable for the whole transaction, even if the requester's inputs change.
  - Wait for pmem_resp with no timeout.
- Completion:
  - In the pmem_resp cycle, mem_resp_x = 1 combinationally and mem_rdata_x = pmem_rdata. The other port's resp stays 0.
  - Next state is IDLE, and last_grant is updated to x.
- Non-granted port: mem_rdata holds its last delivered value; mem_resp = 0.
- Requester drops its request mid-transaction (e.g. flush): the transaction still completes downstream. mem_resp_x still pulses once; the requester must ignore it.
- pmem_resp while in IDLE: ignored; no resp forwarded.
- Back-to-back requests: a request held across the completion cycle is re-arbitrated in the following IDLE cycle. Each transaction therefore costs at least 2 cycles plus memory latency.
- Reset asserted mid-SERVE: strobes drop immediately (async). The in-flight response is discarded and no mem_resp is generated.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined: on simultaneous req_a and req_b in IDLE, grant the port not equal to last_grant (alternating), preventing fetch starvation under heavy load/store traffic.
- Undefined: fixed priority, B always wins ties; last_grant is still maintained but unused.

Test Plan:
- Single fetch: mem_read_a=1, address 0x3000; pmem_resp after 3 cycles with rdata 0x1234 -> pmem_read high from cycle 1 with pmem_address=0x3000; mem_resp_a pulses once with mem_rdata_a=0x1234; mem_resp_b stays 0.
- Store: mem_write_b=1, address 0x4002, wdata 0xBEEF, mask 2'b10 -> pmem_write=1 with exactly those values; mem_resp_b one pulse; pmem_read stays 0.
- Tie, fixed priority: read_a and read_b both held continuously -> grants B, A, B... only because B drops after its resp; with B held 3 back-to-back transactions, A is not served until B deasserts.
- Tie with ARB_ROUND_ROBIN_EN: both held continuously -> grants alternate B, A, B, A; each resp routed to the matching port.
- Input change mid-transaction: after grant, mem_address_b changes 0x4002 -> 0x5000 and mem_read_b drops -> pmem_address stays 0x4002; mem_resp_b still pulses on pmem_resp.
- Reset mid-SERVE_A: reset asserted 1 cycle after grant -> pmem_read=0 immediately; a later pmem_resp produces no mem_resp_a; FSM returns to IDLE.
